// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage
//
// MEM stage of the five-stage RISC-V pipeline. Captures the execute results
// into the EX/MEM register, performs LB/LH/LW/LBU/LHU loads and SB/SH/SW
// stores against a word-organised data RAM, and registers the result into
// MEM/WB. The EX/MEM and MEM/WB values are exported for the execute stage's
// forwarding muxes.
//
// Parameters:
//   DEPTH_WORDS   data RAM depth in 32-bit words (power of two, >= 2)
//
// Ports:
//   clk             rising-edge clock
//   reset           synchronous, active-high
//   alu_result_in   ALU result / load-store byte address from execute
//   store_data_in   forwarded rs2 value for stores
//   rd_in           destination register
//   funct3_in       load/store width and sign selector
//   mem_read_in     instruction is a load
//   mem_write_in    instruction is a store
//   reg_write_in    instruction writes rd
//   flush_in        EX/MEM captures a bubble this edge
//   alu_result_mem  EX/MEM ALU result (forwarding select 10)
//   rd_mem          EX/MEM rd
//   reg_write_mem   EX/MEM reg_write
//   writeback_data  MEM/WB result (forwarding select 01)
//   rd_wb           MEM/WB rd
//   reg_write_wb    MEM/WB reg_write
//   misalign        MEM/WB misaligned-access flag
//
// Configuration macro:
//   MEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses are
//                         flagged, stores are dropped and loads do not
//                         write back. When undefined, accesses are truncated
//                         to their natural alignment and misalign is 0.
// -----------------------------------------------------------------------------
module memory_stage #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  input  logic        flush_in,
  output logic [31:0] alu_result_mem,
  output logic [4:0]  rd_mem,
  output logic        reg_write_mem,
  output logic [31:0] writeback_data,
  output logic [4:0]  rd_wb,
  output logic        reg_write_wb,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // EX/MEM fields not exported directly
  logic [31:0] store_data_q;
  logic [2:0]  funct3_q;
  logic        mem_read_q;
  logic        mem_write_q;

  // ---------------------------------------------------------------------------
  // EX/MEM register. Reset and flush both capture a bubble.
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset || flush_in) begin
      alu_result_mem <= '0;
      store_data_q   <= '0;
      rd_mem         <= '0;
      funct3_q       <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      reg_write_mem  <= 1'b0;
    end else begin
      alu_result_mem <= alu_result_in;
      store_data_q   <= store_data_in;
      rd_mem         <= rd_in;
      funct3_q       <= funct3_in;
      mem_read_q     <= mem_read_in;
      mem_write_q    <= mem_write_in;
      // x0 is never written back
      reg_write_mem  <= reg_write_in && (rd_in != 5'd0);
    end
  end

  // ---------------------------------------------------------------------------
  // Addressing: upper address bits are ignored, so the RAM wraps.
  // ---------------------------------------------------------------------------
  logic [AW-1:0] word_idx;
  logic [1:0]    byte_off;

  assign word_idx = alu_result_mem[AW+1:2];
  assign byte_off = alu_result_mem[1:0];

  // ---------------------------------------------------------------------------
  // Misalignment detection
  // ---------------------------------------------------------------------------
  logic misaligned;

`ifdef MEM_MISALIGN_TRAP_EN
  logic half_op;
  logic word_op;

  assign half_op    = (funct3_q == F3_H) || (mem_read_q && funct3_q == F3_HU);
  assign word_op    = (funct3_q == F3_W);
  assign misaligned = (mem_read_q || mem_write_q) &&
                      ((half_op && byte_off[0]) || (word_op && byte_off != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Data RAM
  // ---------------------------------------------------------------------------
  logic [31:0] ram [DEPTH_WORDS];
  logic [31:0] rdata;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        wr_en;

  assign rdata = ram[word_idx];

  // Replicate the store value across all lanes; the byte enables pick the
  // lane(s) actually written.
  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = 32'h0;
    unique case (funct3_q)
      F3_B: begin
        wr_be   = 4'b0001 << byte_off;
        wr_data = {4{store_data_q[7:0]}};
      end
      F3_H: begin
        wr_be   = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{store_data_q[15:0]}};
      end
      F3_W: begin
        wr_be   = 4'b1111;
        wr_data = store_data_q;
      end
      default: ;
    endcase
  end

  assign wr_en = mem_write_q && !misaligned;

  // NOTE: the RAM array is deliberately left out of reset; reset only
  // suppresses a store whose write edge coincides with it.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) ram[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load lane selection and extension
  // ---------------------------------------------------------------------------
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  assign byte_lane = rdata[8*byte_off +: 8];
  assign half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = 32'h0;
    unique case (funct3_q)
      F3_B:    load_data = {{24{byte_lane[7]}}, byte_lane};
      F3_H:    load_data = {{16{half_lane[15]}}, half_lane};
      F3_W:    load_data = rdata;
      F3_BU:   load_data = {24'h0, byte_lane};
      F3_HU:   load_data = {16'h0, half_lane};
      default: load_data = 32'h0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register. Stores and misaligned accesses never write back.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      writeback_data <= '0;
      rd_wb          <= '0;
      reg_write_wb   <= 1'b0;
      misalign       <= 1'b0;
    end else begin
      writeback_data <= mem_read_q ? load_data : alu_result_mem;
      rd_wb          <= rd_mem;
      reg_write_wb   <= reg_write_mem && !mem_write_q && !misaligned;
      misalign       <= misaligned;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage
//
// Directed and randomized stimulus for memory_stage. Expected values come from
// a byte-addressed memory model and a per-instruction result record computed
// in program order; outputs are sampled 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_memory_stage;

  localparam int DEPTH_WORDS = 256;
  localparam int BYTES       = DEPTH_WORDS * 4;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        reg_write_in;
  logic        flush_in;
  logic [31:0] alu_result_mem;
  logic [4:0]  rd_mem;
  logic        reg_write_mem;
  logic [31:0] writeback_data;
  logic [4:0]  rd_wb;
  logic        reg_write_wb;
  logic        misalign;

  memory_stage #(.DEPTH_WORDS(DEPTH_WORDS)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_result_in  (alu_result_in),
    .store_data_in  (store_data_in),
    .rd_in          (rd_in),
    .funct3_in      (funct3_in),
    .mem_read_in    (mem_read_in),
    .mem_write_in   (mem_write_in),
    .reg_write_in   (reg_write_in),
    .flush_in       (flush_in),
    .alu_result_mem (alu_result_mem),
    .rd_mem         (rd_mem),
    .reg_write_mem  (reg_write_mem),
    .writeback_data (writeback_data),
    .rd_wb          (rd_wb),
    .reg_write_wb   (reg_write_wb),
    .misalign       (misalign)
  );

  always #5 clk = ~clk;

  // Expected results of one instruction
  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw_mem;
    logic [31:0] wb_data;
    logic        chk_data;
    logic [4:0]  wb_rd;
    logic        rw_wb;
    logic        mis;
  } exp_t;

  localparam exp_t BUBBLE = '{alu: 32'h0, rd: 5'h0, rw_mem: 1'b0, wb_data: 32'h0,
                              chk_data: 1'b1, wb_rd: 5'h0, rw_wb: 1'b0, mis: 1'b0};

  int checks = 0;
  int errors = 0;

  logic [7:0] model [BYTES];
  exp_t       prev_e = BUBBLE;

  // Store waiting for the edge that ends its MEM cycle
  logic        pend_valid = 1'b0;
  int          pend_base;
  int          pend_len;
  logic [31:0] pend_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] load_value(input logic [31:0] addr, input logic [2:0] f3);
    int ba = int'(addr % BYTES);
    int hb = ba - (ba % 2);
    int wb = ba - (ba % 4);
    logic [7:0]  b = model[ba];
    logic [15:0] h = {model[hb+1], model[hb]};
    logic [31:0] w = {model[wb+3], model[wb+2], model[wb+1], model[wb]};
    case (f3)
      3'd0:    return 32'($signed(b));
      3'd1:    return 32'($signed(h));
      3'd2:    return w;
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr, input logic [2:0] f3,
                                         input logic rdn, input logic wr);
    int off = int'(addr % 4);
    if (!TRAP_EN) return 1'b0;
    if (rdn && (f3 == 3'd1 || f3 == 3'd5) && (off % 2 != 0)) return 1'b1;
    if (wr && f3 == 3'd1 && (off % 2 != 0)) return 1'b1;
    if ((rdn || wr) && f3 == 3'd2 && off != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_outputs(input exp_t cur);
    check("alu_result_mem", alu_result_mem, cur.alu);
    check("rd_mem", 32'(rd_mem), 32'(cur.rd));
    check("reg_write_mem", 32'(reg_write_mem), 32'(cur.rw_mem));
    if (prev_e.chk_data) check("writeback_data", writeback_data, prev_e.wb_data);
    check("rd_wb", 32'(rd_wb), 32'(prev_e.wb_rd));
    check("reg_write_wb", 32'(reg_write_wb), 32'(prev_e.rw_wb));
    check("misalign", 32'(misalign), 32'(prev_e.mis));
  endtask

  // Present one instruction for one cycle and check the outputs after the edge
  task automatic issue(input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                       input logic [2:0] f3, input logic rdn, input logic wr,
                       input logic rw, input logic fl);
    exp_t e;
    logic mis;
    alu_result_in = addr;
    store_data_in = sd;
    rd_in         = rd;
    funct3_in     = f3;
    mem_read_in   = rdn;
    mem_write_in  = wr;
    reg_write_in  = rw;
    flush_in      = fl;

    // The previous store lands at the same edge that captures this instruction
    if (pend_valid) begin
      for (int k = 0; k < pend_len; k++)
        model[pend_base + k] = pend_data[8*k +: 8];
    end
    pend_valid = 1'b0;

    if (fl) begin
      e = BUBBLE;
    end else begin
      mis        = is_misaligned(addr, f3, rdn, wr);
      e.alu      = addr;
      e.rd       = rd;
      e.rw_mem   = rw && (rd != 5'd0);
      e.wb_data  = rdn ? load_value(addr, f3) : addr;
      e.chk_data = !(rdn && mis);
      e.wb_rd    = rd;
      e.rw_wb    = e.rw_mem && !wr && !mis;
      e.mis      = mis;
      if (wr && !mis && f3 <= 3'd2) begin
        pend_valid = 1'b1;
        pend_len   = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        pend_base  = int'(addr % BYTES);
        pend_base  = pend_base - (pend_base % pend_len);
        pend_data  = sd;
      end
    end

    @(posedge clk);
    #1;
    compare_outputs(e);
    prev_e = e;
  endtask

  task automatic nop();
    issue(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd);
    issue(addr, $urandom, rd, f3, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    issue(addr, data, 5'd0, f3, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Reset edge: pipeline empties and any store in MEM is dropped
  task automatic do_reset();
    reset         = 1'b1;
    alu_result_in = $urandom;
    store_data_in = $urandom;
    rd_in         = 5'd7;
    funct3_in     = 3'd2;
    mem_read_in   = 1'b0;
    mem_write_in  = 1'b1;
    reg_write_in  = 1'b1;
    flush_in      = 1'b0;
    pend_valid    = 1'b0;
    @(posedge clk);
    #1;
    check("rst_alu_result_mem", alu_result_mem, 32'h0);
    check("rst_rd_mem", 32'(rd_mem), 32'h0);
    check("rst_reg_write_mem", 32'(reg_write_mem), 32'h0);
    check("rst_writeback_data", writeback_data, 32'h0);
    check("rst_rd_wb", 32'(rd_wb), 32'h0);
    check("rst_reg_write_wb", 32'(reg_write_wb), 32'h0);
    check("rst_misalign", 32'(misalign), 32'h0);
    prev_e = BUBBLE;
    reset  = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int          kind;

    // Power-on reset
    do_reset();
    do_reset();

    // Initialise the words used by the test (bytes 0x00..0x7F)
    for (int i = 0; i < 32; i++) store(3'd2, 32'(i * 4), 32'h0);

    // Word store then load
    store(3'd2, 32'h10, 32'hDEADBEEF);
    load(3'd2, 32'h10, 5'd9);
    nop();
    check("sw_lw_data", writeback_data, 32'hDEADBEEF);
    check("sw_lw_rd", 32'(rd_wb), 32'd9);

    // Sub-word load extension
    store(3'd2, 32'h20, 32'h80FF7F01);
    load(3'd0, 32'h21, 5'd1);
    load(3'd0, 32'h22, 5'd2);
    check("lb_21", writeback_data, 32'h0000007F);
    load(3'd4, 32'h23, 5'd3);
    check("lb_22", writeback_data, 32'hFFFFFFFF);
    load(3'd1, 32'h22, 5'd4);
    check("lbu_23", writeback_data, 32'h00000080);
    load(3'd5, 32'h20, 5'd5);
    check("lh_22", writeback_data, 32'hFFFF80FF);
    nop();
    check("lhu_20", writeback_data, 32'h00007F01);

    // Byte and half stores
    store(3'd0, 32'h32, 32'h123456AB);
    store(3'd1, 32'h30, 32'hFFFF1234);
    load(3'd2, 32'h30, 5'd6);
    nop();
    check("sb_sh_word", writeback_data, 32'h00AB1234);

    // Flush and x0
    issue(32'h1234, 32'h0, 5'd5, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("flush_rw_mem", 32'(reg_write_mem), 32'h0);
    issue(32'h5555, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_rw_wb", 32'(reg_write_wb), 32'h0);
    nop();
    check("x0_rw_wb", 32'(reg_write_wb), 32'h0);

    // Address wrap
    store(3'd2, 32'h400, 32'h55AA55AA);
    load(3'd2, 32'h0, 5'd7);
    nop();
    check("wrap_alias", writeback_data, 32'h55AA55AA);

    // Reset on the write edge of a store suppresses it
    store(3'd2, 32'h3C, 32'h11111111);
    do_reset();
    load(3'd2, 32'h3C, 5'd8);
    nop();
    check("rst_store_dropped", writeback_data, 32'h0);

    // Misaligned word store
    store(3'd2, 32'h42, 32'hCAFEF00D);
    load(3'd2, 32'h40, 5'd10);
    check("misalign_sw", 32'(misalign), TRAP_EN ? 32'h1 : 32'h0);
    nop();
    check("misalign_lw", writeback_data, TRAP_EN ? 32'h0 : 32'hCAFEF00D);

    // Randomized traffic inside the initialised region (with aliasing)
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 2));
      a    = ($urandom & ~32'h3FF) | 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0)
        issue($urandom, $urandom, 5'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b1, 1'b1);
      else if (kind == 0)
        issue($urandom, $urandom, 5'($urandom), 3'($urandom), 1'b0, 1'b0,
              1'($urandom), 1'b0);
      else if (kind == 1)
        load(3'($urandom), a, 5'($urandom));
      else
        store(3'($urandom_range(0, 3)), a, $urandom);
    end
    nop();
    nop();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the five-stage RISC-V core, directly downstream of the execute stage. Captures execute results into the EX/MEM register and performs byte/half/word loads and stores against a word-organised data RAM. Registers results into MEM/WB and exports the MEM- and WB-stage values and destinations that the execute stage's forwarding muxes consume.

## Interface
Parameters:
- DEPTH_WORDS, 256 — data RAM depth in 32-bit words; power of two.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- reset  in  1  — synchronous, active-high.
- alu_result_in  in  32  — execute ALU result; load/store byte address.
- store_data_in  in  32  — forwarded rs2 value, used for stores.
- rd_in  in  5  — destination register.
- funct3_in  in  3  — load/store width and sign selector.
- mem_read_in  in  1  — instruction is a load.
- mem_write_in  in  1  — instruction is a store.
- reg_write_in  in  1  — instruction writes rd.
- flush_in  in  1  — EX/MEM captures a bubble this edge.
- alu_result_mem  out  32  — EX/MEM ALU result; feeds the execute forwarding path (forward select 10).
- rd_mem  out  5  — EX/MEM rd, for the forwarding unit.
- reg_write_mem  out  1  — EX/MEM reg_write, for the forwarding unit.
- writeback_data  out  32  — MEM/WB result, load data or ALU result; feeds execute forwarding (select 01).
- rd_wb  out  5  — MEM/WB rd.
- reg_write_wb  out  1  — MEM/WB reg_write.
- misalign  out  1  — MEM/WB misaligned-access flag.

## Operation
- **EX/MEM capture:** each edge registers all *_in values.
  - flush_in=1 or reset: capture a bubble. All of reg_write, mem_read and mem_write are 0; rd=0; data fields are 0.
- **Addressing:**
  - Word index = alu_result_mem[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Byte offset = alu_result_mem[1:0].
- **Loads:** read is combinational from the RAM during the MEM cycle, then the lane is selected by the byte offset.
  - 000 LB: sign-extended byte.
  - 001 LH: sign-extended half.
  - 010 LW: full word.
  - 100 LBU: zero-extended byte.
  - 101 LHU: zero-extended half.
  - Any other funct3 returns 0.
  - Half-word lane is offset[1]; byte lane is offset[1:0].
- **Stores:** byte-enabled write at the edge that ends the MEM cycle.
  - 000 SB: store_data[7:0] to the addressed byte.
  - 001 SH: store_data[15:0] to the addressed half.
  - 010 SW: full word.
  - Other funct3: no write.
- **MEM/WB capture:**
  - writeback_data = load data if mem_read, else alu_result_mem.
  - rd_wb and reg_write_wb are copied from EX/MEM.
  - A store or bubble yields reg_write_wb=0.
- **Write to x0:** rd=0 is always written back with reg_write forced to 0, in both the EX/MEM and MEM/WB registers.
- **Reset:** RAM contents are not reset. Pipeline registers reset as listed under Timing.
- **Simultaneous reset and flush_in:** reset wins; both produce the same bubble anyway.

## Timing
- **Latency:** inputs presented in cycle N appear on *_mem outputs after edge N. writeback_data, rd_wb and reg_write_wb follow after edge N+1.
- **Store visibility:** a store in MEM in cycle N writes at edge N+1. A load in MEM in cycle N+1 to the same word returns the new data (no forwarding needed inside the block).
- **Back-to-back:** a store and a load to the same address in adjacent instructions behave as above. A load followed by a dependent instruction needs one bubble (flush_in) from the hazard unit; this block does not detect the hazard.
- **Reset values:**
  - alu_result_mem = 0; rd_mem = 0; reg_write_mem = 0.
  - writeback_data = 0; rd_wb = 0; reg_write_wb = 0; misalign = 0.
  - Internal mem_read/mem_write = 0.
- **Reset mid-store:** a store whose write edge coincides with reset=1 is suppressed.

## Configuration
- **MEM_MISALIGN_TRAP_EN defined:**
  - LH/LHU/SH with offset[0]=1, or LW/SW with offset≠0, count as misaligned.
  - A misaligned store writes nothing.
  - A misaligned load writes back with reg_write_wb=0.
  - misalign=1 in MEM/WB for that instruction.
- **MEM_MISALIGN_TRAP_EN undefined:**
  - Half accesses ignore offset[0]; word accesses ignore offset[1:0] (access is truncated to alignment).
  - misalign is tied to 0.

## Test plan
- **Word store then load:** SW 0xDEADBEEF at addr 0x10, next instruction LW 0x10 → writeback_data=0xDEADBEEF with rd_wb=rd, two edges after the LW is presented.
- **Sub-word load extension:** word 0x80FF7F01 at 0x20; LB 0x21→0x0000007F, LB 0x22→0xFFFFFFFF, LBU 0x23→0x00000080, LH 0x22→0xFFFF80FF, LHU 0x20→0x00007F01.
- **Byte/half stores:** SB 0xAB to 0x32 over word 0 → word 0x00AB0000; then SH 0x1234 to 0x30 → 0x00AB1234.
- **Flush and x0:** flush_in=1 with reg_write_in=1, rd=5 → reg_write_mem=0, then reg_write_wb=0. A separate ALU op with rd=0 → reg_write_wb=0.
- **Wrap and reset:**
  - With DEPTH_WORDS=256, SW to 0x400 aliases 0x000.
  - Assert reset during a SW edge → RAM is unchanged and all outputs are 0 next cycle.
- **Misalignment (macro-dependent):** SW to 0x42, then LW from 0x40.
  - With MEM_MISALIGN_TRAP_EN: the store writes nothing and misalign=1 on the SW.
  - Without it: the store goes to word 0x40 and misalign=0.
